// File: rtl/oled_frame_scheduler_if.sv
// Byte stream, frame RAM read port and control lines between the
// OLED frame scheduler and its RAMs / I2C writer.
interface oled_frame_scheduler_if;
  logic        enable;
  logic        hold;
  logic        sel_force_valid;
  logic [1:0]  sel_force;
  logic [9:0]  ram_read_addr;
  logic [31:0] ram_rdata;
  logic [1:0]  buf_sel;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_start;
  logic        frame_done;
  logic        busy;

  modport master (
    input  enable,
    input  hold,
    input  sel_force_valid,
    input  sel_force,
    input  ram_rdata,
    input  byte_ready,
    output ram_read_addr,
    output buf_sel,
    output byte_data,
    output byte_valid,
    output frame_start,
    output frame_done,
    output busy
  );

  modport slave (
    output enable,
    output hold,
    output sel_force_valid,
    output sel_force,
    output ram_rdata,
    output byte_ready,
    input  ram_read_addr,
    input  buf_sel,
    input  byte_data,
    input  byte_valid,
    input  frame_start,
    input  frame_done,
    input  busy
  );
endinterface

// File: rtl/oled_frame_scheduler.sv
// Streams 1024-byte frames from one of four frame RAMs, switching
// buffers (dwell auto-advance or forced) only on frame boundaries.
module oled_frame_scheduler #(
  parameter int unsigned DWELL_CYCLES = 27_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  oled_frame_scheduler_if.master bus
);

  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    LOAD,
    SEND
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    addr_q, addr_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          fpend_q, fpend_d;
  logic [1:0]    fval_q, fval_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fs_q, fs_d;
  logic          fd_q, fd_d;

  logic expired;
  logic sel_wr;
  logic force_use;

  assign expired = (dwell_q >= DWELL_MAX);

  assign bus.ram_read_addr = addr_q;
  assign bus.buf_sel       = sel_q;
  assign bus.byte_data     = data_q;
  assign bus.byte_valid    = valid_q;
  assign bus.frame_start   = fs_q;
  assign bus.frame_done    = fd_q;
  assign bus.busy          = (state_q != IDLE);

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dwell_q <= '0;
      fpend_q <= 1'b0;
      fval_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dwell_q <= dwell_d;
      fpend_q <= fpend_d;
      fval_q  <= fval_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  // Frame sequencer: address/load/send per byte, buffer switch at wrap.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fs_d      = fs_q;
    fd_d      = 1'b0;
    sel_wr    = 1'b0;
    force_use = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fpend_q) begin
          sel_d     = fval_q;
          sel_wr    = 1'b1;
          force_use = 1'b1;
        end
        if (bus.enable) begin
          state_d = ADDR;
          addr_d  = '0;
        end
      end
      ADDR: begin
        state_d = LOAD;
      end
      LOAD: begin
        data_d  = bus.ram_rdata[{sel_q, 3'b000} +: 8];
        valid_d = 1'b1;
        fs_d    = (addr_q == 10'd0);
        state_d = SEND;
      end
      SEND: begin
        if (bus.byte_ready) begin
          valid_d = 1'b0;
          fs_d    = 1'b0;
          if (addr_q == 10'd1023) begin
            fd_d   = 1'b1;
            addr_d = '0;
            if (fpend_q) begin
              sel_d     = fval_q;
              sel_wr    = 1'b1;
              force_use = 1'b1;
            end else if (expired && !bus.hold) begin
              sel_d  = sel_q + 2'd1;
              sel_wr = 1'b1;
            end
            state_d = bus.enable ? ADDR : IDLE;
          end else begin
            addr_d  = addr_q + 10'd1;
            state_d = ADDR;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Dwell timer: saturating count, restarted on every buffer write.
  always_comb begin
    dwell_d = dwell_q;
    if (sel_wr) begin
      dwell_d = '0;
    end else if (!expired) begin
      dwell_d = dwell_q + DW'(1);
    end
  end

  // Force latch: newest request wins over one being consumed.
  always_comb begin
    fpend_d = fpend_q;
    fval_d  = fval_q;
    if (bus.sel_force_valid) begin
      fpend_d = 1'b1;
      fval_d  = bus.sel_force;
    end else if (force_use) begin
      fpend_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// Directed bench for oled_frame_scheduler: frames, dwell advance,
// backpressure, force/hold, enable drop and mid-frame reset.
module tb_oled_frame_scheduler;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  oled_frame_scheduler_if bus ();

  oled_frame_scheduler #(
    .DWELL_CYCLES(5000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered RAM model: byte = {buffer, addr[5:0]}.
  always @(posedge clk) begin
    bus.ram_rdata <= {2'd3, bus.ram_read_addr[5:0],
                      2'd2, bus.ram_read_addr[5:0],
                      2'd1, bus.ram_read_addr[5:0],
                      2'd0, bus.ram_read_addr[5:0]};
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, bus.byte_valid, 0);
    chk({tag, "_data"}, bus.byte_data, 0);
    chk({tag, "_fs"}, bus.frame_start, 0);
    chk({tag, "_fd"}, bus.frame_done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_sel"}, bus.buf_sel, 0);
    chk({tag, "_addr"}, bus.ram_read_addr, 0);
  endtask

  // act: 0 none, 1 force fv, 2 drop enable, 3 assert reset (abort).
  task automatic run_frame(input logic [1:0] eb,
                           input logic [1:0] en_next,
                           input bit bp, input int act_at,
                           input int act, input logic [1:0] fv,
                           output bit aborted);
    int w;
    logic [7:0] d0;
    aborted = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      w = 0;
      while (!bus.byte_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("valid_wait", bus.byte_valid, 1);
      if (!bus.byte_valid) begin
        aborted = 1'b1;
        return;
      end
      if (!bp && i > 0) chk("byte_gap", w, 2);
      chk("byte_data", bus.byte_data, {eb, i[5:0]});
      chk("frame_start", bus.frame_start, (i == 0));
      chk("buf_sel", bus.buf_sel, eb);
      chk("rd_addr", bus.ram_read_addr, i);
      if (i == act_at) begin
        case (act)
          1: begin
            bus.sel_force_valid = 1'b1;
            bus.sel_force = fv;
          end
          2: bus.enable = 1'b0;
          3: begin
            rst = 1'b1;
            #1;
            chk_zero("mid_rst");
            aborted = 1'b1;
            return;
          end
          default: ;
        endcase
      end
      if (bp) begin
        d0 = bus.byte_data;
        w = 0;
        while ($urandom_range(0, 99) >= 30 && w < 100) begin
          bus.byte_ready = 1'b0;
          @(negedge clk);
          bus.sel_force_valid = 1'b0;
          w++;
          chk("bp_valid", bus.byte_valid, 1);
          chk("bp_data", bus.byte_data, d0);
        end
      end
      bus.byte_ready = 1'b1;
      @(negedge clk);
      bus.sel_force_valid = 1'b0;
      if (bp) bus.byte_ready = 1'b0;
      chk("accepted", bus.byte_valid, 0);
      if (i == 1023) begin
        chk("frame_done", bus.frame_done, 1);
        chk("next_buf", bus.buf_sel, en_next);
        @(negedge clk);
        chk("done_pulse", bus.frame_done, 0);
      end else begin
        chk("no_done", bus.frame_done, 0);
      end
    end
    bus.byte_ready = 1'b1;
  endtask

  initial begin
    int w;
    bit ab;
    logic [1:0] seq [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2,
                             2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.hold = 1'b0;
    bus.sel_force_valid = 1'b0;
    bus.sel_force = 2'd0;
    bus.byte_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic frame from a one-cycle enable pulse.
    bus.enable = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
      bus.enable = 1'b0;
    end while (!bus.byte_valid && w < 20);
    chk("latency", w, 3);
    run_frame(2'd0, 2'd0, 1'b0, -1, 0, 2'd0, ab);
    chk("idle_busy", bus.busy, 0);

    // Force in IDLE: latched one edge, applied the next.
    bus.sel_force_valid = 1'b1;
    bus.sel_force = 2'd3;
    @(negedge clk);
    bus.sel_force_valid = 1'b0;
    chk("idle_force_wait", bus.buf_sel, 0);
    @(negedge clk);
    chk("idle_force", bus.buf_sel, 3);
    bus.sel_force_valid = 1'b1;
    bus.sel_force = 2'd0;
    @(negedge clk);
    bus.sel_force_valid = 1'b0;
    @(negedge clk);
    chk("idle_force0", bus.buf_sel, 0);

    // Auto-advance with enable held; drop enable in the last frame.
    bus.enable = 1'b1;
    for (int f = 0; f < 9; f++) begin
      run_frame(seq[f], seq[f+1], 1'b0, (f == 8) ? 300 : -1,
                (f == 8) ? 2 : 0, 2'd0, ab);
    end
    chk("drop_busy", bus.busy, 0);

    // Backpressure frame, force to 2 at byte 500 beats expiry.
    bus.enable = 1'b1;
    run_frame(2'd0, 2'd2, 1'b1, 500, 1, 2'd2, ab);

    // Hold keeps buffer 2; a force to 3 still lands.
    bus.hold = 1'b1;
    for (int h = 0; h < 5; h++) begin
      run_frame(2'd2, (h == 4) ? 2'd3 : 2'd2, 1'b0,
                (h == 4) ? 100 : -1, (h == 4) ? 1 : 0, 2'd3, ab);
    end
    bus.hold = 1'b0;

    // Force to 1 at the boundary where buffer 3 has expired.
    run_frame(2'd3, 2'd3, 1'b0, -1, 0, 2'd0, ab);
    run_frame(2'd3, 2'd1, 1'b0, 600, 1, 2'd1, ab);
    run_frame(2'd1, 2'd1, 1'b0, -1, 0, 2'd0, ab);

    // Reset at byte 200, then restart from buffer 0, address 0.
    run_frame(2'd1, 2'd1, 1'b0, 200, 3, 2'd0, ab);
    chk("rst_abort", ab, 1);
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_sel", bus.buf_sel, 0);
    chk("post_rst_busy", bus.busy, 0);
    bus.enable = 1'b1;
    run_frame(2'd0, 2'd0, 1'b0, 1000, 2, 2'd0, ab);
    chk("final_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
